// File: rtl/wb_write_sequencer_if.sv
// ---------------------------------------------------------------------------
// wb_write_sequencer_if
// Bundles the requester handshake and the memory write port of the
// write-back sequencer.
//   req_valid  [NUM_REQ]     requester word available
//   req_data   [NUM_REQ*32]  requester i word at bits [32*i+31:32*i]
//   req_ready  [NUM_REQ]     one-hot grant from the sequencer
//   write_en                 memory write strobe
//   addr       [ADDR_W]      memory byte address
//   inp        [0:3][7:0]    write bytes, inp[0] is the most significant byte
// Modports: master = sequencer side, slave = requesters + memory side.
// ---------------------------------------------------------------------------
interface wb_write_sequencer_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  write_en;
    logic [ADDR_W-1:0]     addr;
    logic [0:3][7:0]       inp;

    modport master (
        input  req_valid,
        input  req_data,
        output req_ready,
        output write_en,
        output addr,
        output inp
    );

    modport slave (
        output req_valid,
        output req_data,
        input  req_ready,
        input  write_en,
        input  addr,
        input  inp
    );
endinterface

// File: rtl/wb_write_sequencer.sv
// ---------------------------------------------------------------------------
// wb_write_sequencer
// Collects result words from NUM_REQ requesters with a round-robin arbiter
// (one word per cycle) and writes them to consecutive word addresses of the
// shared memory, starting at BASE_ADDR. After TOTAL_WORDS words the block
// drains for two edges and raises done, which triggers the memory dump.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle pulse, begins a run from IDLE or DONE
//   bus         requester handshake + memory write port (master modport)
//   done        level, all TOTAL_WORDS committed
//   busy        high while the run or drain is in progress
//   word_count  words accepted in the current run
// ---------------------------------------------------------------------------
module wb_write_sequencer #(
    parameter int  CAPACITY    = 256,
    parameter int  NUM_REQ     = 4,
    parameter int  TOTAL_WORDS = 43,
    parameter int  BASE_ADDR   = 0,
    localparam int ADDR_W      = $clog2(CAPACITY),
    localparam int CNT_W       = $clog2(TOTAL_WORDS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    wb_write_sequencer_if.master       bus,
    output logic                       done,
    output logic                       busy,
    output logic [CNT_W-1:0]           word_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;

    logic                 write_en_r;
    logic                 write_en_next_s;
    logic [ADDR_W-1:0]    addr_r;
    logic [ADDR_W-1:0]    addr_next_s;
    logic [0:3][7:0]      inp_r;
    logic [0:3][7:0]      inp_next_s;
    logic [ADDR_W-1:0]    addr_cnt_r;
    logic [ADDR_W-1:0]    addr_cnt_next_s;
    logic [CNT_W-1:0]     word_count_r;
    logic [CNT_W-1:0]     word_count_next_s;
    logic [PTR_W-1:0]     ptr_r;
    logic [PTR_W-1:0]     ptr_next_s;
    logic                 done_r;
    logic                 done_next_s;
    logic                 busy_r;
    logic                 busy_next_s;

    logic [NUM_REQ-1:0]   grant_s;
    logic [PTR_W-1:0]     grant_idx_s;
    logic                 grant_any_s;
    logic [31:0]          grant_word_s;
    logic                 hit_s;
    logic                 handshake_s;
    int                   cand_s;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_s      = '0;
        grant_idx_s  = '0;
        grant_any_s  = 1'b0;
        cand_s       = 0;
        hit_s        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s               = (int'(ptr_r) + i) % NUM_REQ;
            hit_s                = !grant_any_s && bus.req_valid[cand_s];
            grant_s[cand_s]      = grant_s[cand_s] | hit_s;
            grant_idx_s          = hit_s ? PTR_W'(cand_s) : grant_idx_s;
            grant_any_s          = grant_any_s | hit_s;
        end
        grant_word_s = bus.req_data[int'(grant_idx_s) * 32 +: 32];
    end

    // Grants are only offered while running, so no word is taken in drain or done.
    assign bus.req_ready = (state_r == ST_RUN) ? grant_s : '0;
    assign handshake_s   = (state_r == ST_RUN) && grant_any_s;

    // Next-state and datapath update for the run sequence.
    always_comb begin
        state_next_s      = state_r;
        write_en_next_s   = 1'b0;
        addr_next_s       = addr_r;
        inp_next_s        = inp_r;
        addr_cnt_next_s   = addr_cnt_r;
        word_count_next_s = word_count_r;
        ptr_next_s        = ptr_r;
        done_next_s       = done_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s      = ST_RUN;
                    word_count_next_s = '0;
                    addr_cnt_next_s   = ADDR_W'(BASE_ADDR);
                end else begin
                    state_next_s      = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (handshake_s) begin
                    write_en_next_s   = 1'b1;
                    addr_next_s       = addr_cnt_r;
                    inp_next_s        = grant_word_s;
                    addr_cnt_next_s   = addr_cnt_r + ADDR_W'(4);
                    word_count_next_s = word_count_r + CNT_W'(1);
                    ptr_next_s        = PTR_W'((int'(grant_idx_s) + 1) % NUM_REQ);
                    if (word_count_r == CNT_W'(TOTAL_WORDS - 1)) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    write_en_next_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                // First drain edge retires the final strobe; the next one raises
                // done, so done never shares an edge with the last memory commit.
                if (write_en_r) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_DONE;
                    done_next_s  = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s      = ST_RUN;
                    done_next_s       = 1'b0;
                    word_count_next_s = '0;
                    addr_cnt_next_s   = ADDR_W'(BASE_ADDR);
                end else begin
                    state_next_s      = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                done_next_s  = 1'b0;
            end
        endcase

        busy_next_s = (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_en_r   <= 1'b0;
            addr_r       <= '0;
            inp_r        <= '0;
            addr_cnt_r   <= '0;
            word_count_r <= '0;
            ptr_r        <= '0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            write_en_r   <= write_en_next_s;
            addr_r       <= addr_next_s;
            inp_r        <= inp_next_s;
            addr_cnt_r   <= addr_cnt_next_s;
            word_count_r <= word_count_next_s;
            ptr_r        <= ptr_next_s;
            done_r       <= done_next_s;
            busy_r       <= busy_next_s;
        end
    end

    assign bus.write_en = write_en_r;
    assign bus.addr     = addr_r;
    assign bus.inp      = inp_r;
    assign done         = done_r;
    assign busy         = busy_r;
    assign word_count   = word_count_r;

endmodule

// File: doc/wb_write_sequencer.md
Name: wb_write_sequencer

Overview:
- Sequences result write-back from NUM_REQ processing requesters into the shared word memory.
- Arbitrates the requesters round-robin, one word per cycle.
- Generates byte addresses incrementing by 4 and drives the memory write_en/addr/inp[0:3] port.
- Raises done after exactly TOTAL_WORDS words are committed, which triggers the memory dump to file.

Parameters:
- CAPACITY, 256: memory byte-address space; ADDR_W = $clog2(CAPACITY).
- NUM_REQ, 4: number of requesters, >= 1.
- TOTAL_WORDS, 43: words written per run; BASE_ADDR + 4*TOTAL_WORDS <= CAPACITY is required.
- BASE_ADDR, 0: first byte address, multiple of 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- req_valid  in  NUM_REQ  per-requester word available.
- req_data  in  NUM_REQ*32  requester i word at bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  one-hot grant; transfer on valid&ready at a rising clk.
- write_en  out  1  memory write strobe.
- addr  out  ADDR_W  memory byte address.
- inp  out  8 x [0:3]  bytes, inp[0]=data[31:24] through inp[3]=data[7:0].
- done  out  1  all TOTAL_WORDS committed; level output.
- busy  out  1  high in RUN and DRAIN.
- word_count  out  $clog2(TOTAL_WORDS+1)  words accepted this run.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, write_en=0, addr=0, inp all 0, done=0, busy=0, word_count=0.
  - RR pointer=0, req_ready=0.
  - Reset mid-run abandons the run; done falls immediately.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - req_ready=0.
  - start=1 -> RUN at next edge; word_count cleared to 0, address counter loaded with BASE_ADDR.
- RUN:
  - req_ready is combinational from req_valid and the RR pointer.
  - The lowest-index valid requester at or after the pointer, wrapping modulo NUM_REQ, gets ready=1; all others get 0.
  - No valid requester -> req_ready=0.
  - On handshake with requester g at an edge:
    - write_en<=1, addr<=address counter, inp<=bytes of req_data[g].
    - address counter += 4, word_count += 1.
    - RR pointer <= (g+1) mod NUM_REQ.
  - No handshake at an edge -> write_en<=0; addr and inp hold their values.
  - Latency: handshake edge k -> write_en high during cycle k..k+1 -> memory commits at edge k+1.
  - The handshake that makes word_count==TOTAL_WORDS -> DRAIN at the same edge.
  - req_ready is 0 outside RUN, so no extra word is ever accepted.
- DRAIN:
  - Edge k+1: write_en<=0, state stays DRAIN.
  - Edge k+2: done<=1, state -> DONE.
  - This keeps done strictly after the final memory write, with no same-edge race against the dump.
- DONE:
  - done=1 held, busy=0, req_ready=0, write_en=0.
  - start=1 -> done<=0, word_count<=0, address counter<=BASE_ADDR, RR pointer kept, state -> RUN.
- start is ignored in RUN and DRAIN.
- busy=1 exactly in RUN and DRAIN.
- The address counter never exceeds BASE_ADDR+4*(TOTAL_WORDS-1) on addr; there is no wrap-around within a run.
- req_valid is sampled only in RUN. A requester may drop valid without a handshake, which simply re-arbitrates the next cycle.
- NUM_REQ=1 degenerates to ready=req_valid[0] in RUN.

Test Plan:
1. Reset then start; requester 0 only, valid continuously with data 0x00000000+n -> writes at addr 0,4,...,168 with inp={00,00,00,n}. Last write_en seen 43 cycles after the first ready; done rises 2 edges after the final handshake; word_count=43.
2. All 4 requesters valid continuously -> grants cycle 0,1,2,3,0,...; word j comes from requester j mod 4 at addr 4*j. Exactly 43 writes, no grant after word 43.
3. Only requesters 1 and 3 valid, with requester 3 dropping valid every other cycle -> grants alternate fairly. Bubbles give write_en=0 with addr held. Total write_en pulses = 43.
4. Pulse start during RUN at word 10 -> no effect: addresses continue 40,44,..., word_count is not cleared.
5. Assert rst low after 20 words -> all outputs return to reset values in the same cycle with no clock edge needed. A subsequent start begins again at BASE_ADDR with word_count 0.
6. In DONE, pulse start -> done falls at the next edge and a second run rewrites addr 0..168. done rises again only after word 43 of the new run is committed.
